// File: rtl/axi_addr_trace_ctrl.sv
// AXI AW/AR address trace capture: arbitrates handshakes into one time-ordered log with arm/stop control.
// Optional macro TRACE_WRAP_EN: ring buffer with sticky overflow instead of stop-on-full.
module axi_addr_trace_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arm,
    input  logic              stop,
    input  logic              rd_req,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [ADDR_W:0]   rd_data,
    output logic [1:0]        state,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic [7:0]        dropped
);
    localparam int unsigned EW = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [7:0]        dropped_q, dropped_d;
    logic              prio_q, prio_d;
    logic              skid_vld_q, skid_vld_d;
    logic [EW-1:0]     skid_q, skid_d;
    logic              ovf_q;
    logic              rd_valid_q;
    logic [EW-1:0]     rd_data_q;
    logic [EW-1:0]     mem [DEPTH];

    logic              aw_hs, ar_hs, both_hs;
    logic [EW-1:0]     aw_e, ar_e, ev0, ev1, c0, c1;
    logic [1:0]        n_cand, n_drop;
    logic [8:0]        drop_sum;
    logic              mem_we;
    logic [PTR_W-1:0]  rd_slot;
    logic              rd_hit;

`ifdef TRACE_WRAP_EN
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    logic ovf_d;
`else
    localparam logic [PTR_W:0] LAST_CNT = (PTR_W+1)'(DEPTH - 1);
    assign ovf_q = 1'b0;
`endif

    always_comb begin
        aw_hs   = awvalid & awready;
        ar_hs   = arvalid & arready;
        both_hs = aw_hs & ar_hs;
        aw_e    = {1'b0, awaddr};
        ar_e    = {1'b1, araddr};
        // Candidate order: skid first, then new events with prio choosing AW/AR on a tie.
        ev0     = ((both_hs & prio_q) | (~aw_hs & ar_hs)) ? ar_e : aw_e;
        ev1     = prio_q ? aw_e : ar_e;
        n_cand  = {1'b0, skid_vld_q} + {1'b0, aw_hs} + {1'b0, ar_hs};
        c0      = skid_vld_q ? skid_q : ev0;
        c1      = skid_vld_q ? ev0 : ev1;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        dropped_d  = dropped_q;
        prio_d     = prio_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        n_drop     = '0;
        mem_we     = 1'b0;
        drop_sum   = '0;
`ifdef TRACE_WRAP_EN
        ovf_d      = ovf_q;
`endif

        if (arm) begin
            state_d    = ST_RUN;
            wr_ptr_d   = '0;
            count_d    = '0;
            skid_vld_d = 1'b0;
`ifdef TRACE_WRAP_EN
            ovf_d      = 1'b0;
`endif
        end else if (state_q == ST_RUN) begin
            if (stop) begin
                state_d    = ST_DONE;
                skid_vld_d = 1'b0;
                n_drop     = {1'b0, skid_vld_q};
            end else begin
                if (both_hs) begin
                    prio_d = ~prio_q;
                end
                skid_vld_d = 1'b0;
                if (n_cand != 2'd0) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef TRACE_WRAP_EN
                    if (count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (n_cand >= 2'd2) begin
                        skid_vld_d = 1'b1;
                        skid_d     = c1;
                    end
                    if (n_cand == 2'd3) begin
                        n_drop = 2'd1;
                    end
`else
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        n_drop  = n_cand - 2'd1;
                    end else begin
                        if (n_cand >= 2'd2) begin
                            skid_vld_d = 1'b1;
                            skid_d     = c1;
                        end
                        if (n_cand == 2'd3) begin
                            n_drop = 2'd1;
                        end
                    end
`endif
                end
            end
        end

        drop_sum = {1'b0, dropped_q} + {7'd0, n_drop};
        if (arm) begin
            dropped_d = '0;
        end else begin
            dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            prio_q     <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            dropped_q  <= dropped_d;
            prio_q     <= prio_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

`ifdef TRACE_WRAP_EN
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= c0;
        end
    end

    // Once wrapped, the oldest entry sits at the write pointer.
    assign rd_slot = ovf_q ? (wr_ptr_q + rd_idx) : rd_idx;
    assign rd_hit  = ({1'b0, rd_idx} < count_q);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_hit ? mem[rd_slot] : '0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_axi_addr_trace_ctrl.sv
// Bench for axi_addr_trace_ctrl: ordered-log reference model plus directed and random stimulus.
// Honours TRACE_WRAP_EN when defined for the build.
module tb_axi_addr_trace_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;
`ifdef TRACE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef logic [ADDR_W:0] ent_t;

    logic              clk = 1'b0;
    logic              rst_x;
    logic              awvalid, awready, arvalid, arready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              arm, stop, rd_req;
    logic [PTR_W-1:0]  rd_idx;
    logic              rd_valid;
    logic [ADDR_W:0]   rd_data;
    logic [1:0]        state;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic [7:0]        dropped;

    axi_addr_trace_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_x(rst_x),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arm(arm), .stop(stop), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data), .state(state),
        .count(count), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Next-cycle stimulus, applied at the following negedge by tick()
    logic              n_arm, n_stop, n_awv, n_awr, n_arv, n_arr, n_rdq;
    logic [ADDR_W-1:0] n_awa, n_ara;
    logic [PTR_W-1:0]  n_rdi;

    // Reference model: log is oldest-first, capped at DEPTH
    ent_t m_log[$];
    bit   m_skid_v;
    ent_t m_skid;
    int   m_drop;
    int   m_st;
    bit   m_prio;
    bit   m_ovf;
    bit   e_rdv;
    ent_t e_rdd;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_drop(input int n);
        m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
    endtask

    task automatic model_reset();
        m_log.delete();
        m_skid_v = 1'b0;
        m_skid   = '0;
        m_drop   = 0;
        m_st     = 0;
        m_prio   = 1'b0;
        m_ovf    = 1'b0;
        e_rdv    = 1'b0;
        e_rdd    = '0;
    endtask

    task automatic model_step();
        ent_t c[$];
        ent_t aw_e, ar_e;
        bit   awh, arh;
        if (rd_req) begin
            e_rdd = (int'(rd_idx) < m_log.size()) ? m_log[rd_idx] : '0;
        end
        e_rdv = rd_req;
        awh  = awvalid && awready;
        arh  = arvalid && arready;
        aw_e = {1'b0, awaddr};
        ar_e = {1'b1, araddr};
        if (arm) begin
            m_log.delete();
            m_skid_v = 1'b0;
            m_drop   = 0;
            m_ovf    = 1'b0;
            m_st     = 1;
        end else if (m_st == 1) begin
            if (stop) begin
                if (m_skid_v) add_drop(1);
                m_skid_v = 1'b0;
                m_st     = 2;
            end else begin
                if (m_skid_v) c.push_back(m_skid);
                if (awh && arh) begin
                    if (!m_prio) begin
                        c.push_back(aw_e);
                        c.push_back(ar_e);
                    end else begin
                        c.push_back(ar_e);
                        c.push_back(aw_e);
                    end
                    m_prio = !m_prio;
                end else if (awh) begin
                    c.push_back(aw_e);
                end else if (arh) begin
                    c.push_back(ar_e);
                end
                m_skid_v = 1'b0;
                if (c.size() > 0) begin
                    m_log.push_back(c[0]);
                    if (m_log.size() > DEPTH) begin
                        void'(m_log.pop_front());
                        m_ovf = 1'b1;
                    end
                    if (!WRAP && m_log.size() == DEPTH) begin
                        m_st = 2;
                        add_drop(c.size() - 1);
                    end else begin
                        if (c.size() > 1) begin
                            m_skid_v = 1'b1;
                            m_skid   = c[1];
                        end
                        if (c.size() > 2) add_drop(c.size() - 2);
                    end
                end
            end
        end
    endtask

    task automatic clear_next();
        n_arm = 0; n_stop = 0; n_awv = 0; n_awr = 0; n_arv = 0; n_arr = 0; n_rdq = 0;
        n_awa = '0; n_ara = '0; n_rdi = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        arm = n_arm; stop = n_stop; rd_req = n_rdq; rd_idx = n_rdi;
        awvalid = n_awv; awready = n_awr; awaddr = n_awa;
        arvalid = n_arv; arready = n_arr; araddr = n_ara;
        model_step();
        clear_next();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(input bit aw, input logic [ADDR_W-1:0] awa, input bit ar, input logic [ADDR_W-1:0] ara);
        n_awv = aw; n_awr = aw; n_awa = awa;
        n_arv = ar; n_arr = ar; n_ara = ara;
        tick();
    endtask

    task automatic read_lit(input logic [PTR_W-1:0] idx, input ent_t exp);
        n_rdq = 1'b1;
        n_rdi = idx;
        tick();
        settle();
        check("lit_rd_valid", 64'(rd_valid), 64'd1);
        check("lit_rd_data", 64'(rd_data), 64'(exp));
    endtask

    // Called between edges; reset is asynchronous so outputs must clear at once.
    task automatic do_reset();
        rst_x = 1'b0;
        arm = 0; stop = 0; rd_req = 0; rd_idx = '0;
        awvalid = 0; awready = 0; awaddr = '0;
        arvalid = 0; arready = 0; araddr = '0;
        model_reset();
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_x = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en && rst_x) begin
            check("state", 64'(state), 64'(m_st));
            check("count", 64'(count), 64'(m_log.size()));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("dropped", 64'(dropped), 64'(m_drop));
            check("rd_valid", 64'(rd_valid), 64'(e_rdv));
            check("rd_data", 64'(rd_data), 64'(e_rdd));
        end
    end

    initial begin
        clear_next();
        #2;
        do_reset();
        chk_en = 1'b1;

        // Three AW writes then stop
        n_arm = 1; tick();
        ev(1, 32'h1000, 0, '0);
        ev(1, 32'h1004, 0, '0);
        ev(1, 32'h1008, 0, '0);
        n_stop = 1; tick();
        settle();
        check("s1_count", 64'(count), 64'd3);
        check("s1_state", 64'(state), 64'd2);
        read_lit(0, {1'b0, 32'h1000});
        read_lit(1, {1'b0, 32'h1004});
        read_lit(2, {1'b0, 32'h1008});
        read_lit(3, '0);

        // Simultaneous events twice, separated by an idle cycle: prio toggles
        n_arm = 1; tick();
        ev(1, 32'hA0, 1, 32'hB0);
        ev(0, '0, 0, '0);
        ev(1, 32'hA4, 1, 32'hB4);
        ev(0, '0, 0, '0);
        settle();
        check("s2_dropped", 64'(dropped), 64'd0);
        read_lit(0, {1'b0, 32'hA0});
        read_lit(1, {1'b1, 32'hB0});
        read_lit(2, {1'b1, 32'hB4});
        read_lit(3, {1'b0, 32'hA4});

        // Simultaneous events on three consecutive cycles
        n_arm = 1; tick();
        ev(1, 32'hC0, 1, 32'hD0);
        ev(1, 32'hC4, 1, 32'hD4);
        ev(1, 32'hC8, 1, 32'hD8);
        ev(0, '0, 0, '0);
        ev(0, '0, 0, '0);
        settle();
        check("s3_count", 64'(count), 64'd4);
        check("s3_dropped", 64'(dropped), 64'd2);

        // Twenty AW handshakes into a 16-entry buffer
        n_arm = 1; tick();
        for (int i = 0; i < 20; i++) ev(1, 32'h2000 + 32'(4 * i), 0, '0);
        settle();
        check("s4_count", 64'(count), 64'd16);
        check("s4_dropped", 64'(dropped), 64'd0);
`ifdef TRACE_WRAP_EN
        check("s4_state", 64'(state), 64'd1);
        check("s4_overflow", 64'(overflow), 64'd1);
        read_lit(0, {1'b0, 32'h2010});
        read_lit(15, {1'b0, 32'h204C});
`else
        check("s4_state", 64'(state), 64'd2);
        read_lit(0, {1'b0, 32'h2000});
        read_lit(15, {1'b0, 32'h203C});
`endif

        // Reset while RUN with the skid occupied
        n_arm = 1; tick();
        ev(1, 32'h3000, 0, '0);
        n_rdq = 1; n_rdi = '0;
        ev(1, 32'h3004, 1, 32'h3008);
        settle();
        check("s5_pre_count", 64'(count), 64'd2);
        check("s5_pre_rd", 64'(rd_data), 64'({1'b0, 32'h3000}));
        do_reset();
        n_arm = 1; tick();
        ev(1, 32'h3100, 0, '0);
        ev(0, '0, 0, '0);
        settle();
        check("s5_count", 64'(count), 64'd1);
        read_lit(0, {1'b0, 32'h3100});

        // arm and stop together from DONE
        n_stop = 1; tick();
        n_arm = 1; n_stop = 1; tick();
        settle();
        check("s6_state", 64'(state), 64'd1);
        check("s6_count", 64'(count), 64'd0);

`ifdef TRACE_WRAP_EN
        // Dropped counter saturation under continuous contention
        n_arm = 1; tick();
        for (int i = 0; i < 300; i++) ev(1, 32'(i), 1, 32'(i + 1000));
        settle();
        check("s7_dropped_sat", 64'(dropped), 64'd255);
        n_stop = 1; tick();
`else
        // Full hit while skid is occupied: the two new events are dropped
        n_arm = 1; tick();
        for (int i = 0; i < 14; i++) ev(1, 32'h4000 + 32'(4 * i), 0, '0);
        ev(1, 32'h5000, 1, 32'h6000);
        ev(1, 32'h5004, 1, 32'h6004);
        settle();
        check("s7_count", 64'(count), 64'd16);
        check("s7_state", 64'(state), 64'd2);
        check("s7_dropped", 64'(dropped), 64'd2);
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            n_arm  = ($urandom_range(0, 99) < ((m_st == 1) ? 2 : 20));
            n_stop = ($urandom_range(0, 99) < 3);
            n_awv  = ($urandom_range(0, 99) < 60);
            n_awr  = ($urandom_range(0, 99) < 60);
            n_arv  = ($urandom_range(0, 99) < 60);
            n_arr  = ($urandom_range(0, 99) < 60);
            n_awa  = $urandom();
            n_ara  = $urandom();
            n_rdq  = ($urandom_range(0, 99) < 50);
            n_rdi  = PTR_W'($urandom_range(0, DEPTH - 1));
            tick();
            if (i % 1500 == 1499) begin
                @(posedge clk);
                #2;
                do_reset();
            end
        end
        settle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_addr_trace_ctrl.md
# axi_addr_trace_ctrl

Capture controller for AXI address-channel debug tracing on the MMIO master port. It arbitrates completed AW and AR handshakes into one shared trace buffer and sequences capture with an arm/stop state machine. It exposes an indexed readout port for a debug register block or ILA. It replaces per-signal fixed capture arrays with a single time-ordered log tagged by channel.

## Interface
Parameters:
- ADDR_W, 32, address width of awaddr/araddr
- DEPTH, 16, trace entries; power of two, ≥2
- PTR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_x  in  1  reset, asynchronous, active-low
- awvalid, awready  in  1  AW channel handshake
- awaddr  in  ADDR_W  AW address
- arvalid, arready  in  1  AR channel handshake
- araddr  in  ADDR_W  AR address
- arm  in  1  one-cycle pulse: clear log and start capture
- stop  in  1  one-cycle pulse: end capture
- rd_req  in  1  readout request
- rd_idx  in  PTR_W  logical entry index, 0 = oldest
- rd_valid  out  1  readout data valid
- rd_data  out  ADDR_W+1  {is_read, addr}; bit ADDR_W = 1 for AR, 0 for AW
- state  out  2  0 IDLE, 1 RUN, 2 DONE
- count  out  PTR_W+1  valid entries, 0..DEPTH
- overflow  out  1  sticky; entries were overwritten
- dropped  out  8  handshakes lost, saturates at 255

## Operation
- Handshake event: aw_hs = awvalid & awready; ar_hs = arvalid & arready. Events are sampled only in RUN.
- FSM transitions:
  - IDLE→RUN on arm.
  - RUN→DONE on stop, or on buffer full in stop-on-full mode.
  - DONE→RUN on arm.
  - arm in RUN restarts capture.
  - arm and stop in the same cycle: arm wins.
- arm clears count, write pointer, overflow, dropped and skid. Capture starts the cycle after arm.
- Per-cycle candidates in RUN, in this order:
  1. skid entry, if valid;
  2. new events, ordered by the prio bit.
- Candidate handling: 1st candidate is written to the buffer, 2nd is held in the one-entry skid, any 3rd increments dropped.
- prio bit resets to 0 (AW first). It toggles only when aw_hs and ar_hs coincide.
- stop while skid is valid: skid is discarded and dropped increments. A handshake in the stop cycle is not logged.
- Readout is legal in any state and is read-before-write.
  - Physical slot = rd_idx if overflow = 0, else (wr_ptr + rd_idx) mod DEPTH.
  - rd_idx ≥ count returns rd_data = 0 with rd_valid still asserted.
- Buffer RAM contents are not reset.

## Timing
- Reset values: state 0, count 0, overflow 0, dropped 0, rd_valid 0, rd_data 0, prio 0, skid empty.
- Write latency: an entry with no skid contention is written at the edge closing its handshake cycle; count updates on that edge. A skid entry is written one cycle later.
- Readout latency: rd_valid/rd_data are registered 1 cycle after rd_req. rd_valid deasserts the cycle after rd_req drops.
- Full in stop-on-full mode:
  - The write that makes count = DEPTH moves state to DONE on the same edge.
  - Other candidates in that cycle, and the skid entry, count as dropped.
  - count never exceeds DEPTH.
- Reset mid-operation forces all reset values immediately, independent of clk.

## Configuration
- TRACE_WRAP_EN defined: the buffer is a ring.
  - On full, the oldest entry is overwritten and overflow sets.
  - count holds at DEPTH; state stays RUN until stop.
- TRACE_WRAP_EN undefined: stop-on-full as above; overflow is tied to 0.

## Test plan
- Reset, arm, 3 AW handshakes (0x1000, 0x1004, 0x1008), stop → count=3, DONE, rd_idx 0..2 return {0,0x1000},{0,0x1004},{0,0x1008}, rd_idx 3 returns 0.
- Simultaneous aw_hs 0xA0 / ar_hs 0xB0 twice → order AW 0xA0, AR 0xB0, then AR 0xB4, AW 0xA4 (prio toggled); dropped=0.
- Simultaneous events on 3 consecutive cycles (6 handshakes) → 4 logged, dropped=2 (skid occupied each cycle).
- DEPTH=16, 20 AW handshakes, macro off → count=16, state DONE after 16th, dropped=0 (no further events sampled); macro on → count=16, overflow=1, rd_idx 0 = 5th address.
- rst_x low during RUN with skid valid → all outputs at reset values asynchronously; arm afterwards logs from count 0.
- arm and stop in the same cycle from DONE → state RUN, log cleared.
